// File: rtl/wb_stage.sv
// RV32I writeback stage: holds one instruction from the memory stage, waits for
// load data when needed, and drives the register-file write port plus a retire counter.
module wb_stage #(
  parameter int RET_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_Mem,
  output logic             ready_Mem,
  input  logic             flush_Wb,
  input  logic [31:0]      pc_Mem,
  input  logic [31:0]      inst_Mem,
  input  logic [31:0]      alu_Mem,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             reg_write_en,
  output logic [31:0]      inst_Wb,
  output logic [31:0]      wb_mux_out_Wb,
  output logic [31:0]      pc_Wb,
  output logic             retire,
  output logic [RET_W-1:0] instret
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT_LD = 2'd1,
    S_WRITE   = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, inst_q, alu_q, ld_q;
  logic [RET_W-1:0]  instret_q;
  logic              cap_s;
  logic              wr_op_s;
  logic [31:0]       result_s;
  logic [31:0]       u_imm_s;

  // Extract and extend the addressed byte/halfword from a word-aligned read.
  function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign ready_Mem = (state_q != S_WAIT_LD);
  assign cap_s     = valid_Mem & ready_Mem & ~flush_Wb;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY, S_WRITE: begin
        if (cap_s) begin
          state_d = (inst_Mem[6:0] == OP_LOAD) ? S_WAIT_LD : S_WRITE;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_WAIT_LD: begin
        if (flush_Wb) begin
          state_d = S_EMPTY;
        end else if (dmem_rvalid) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT_LD;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Instruction holding registers and captured load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= 32'h0000_0000;
      inst_q <= 32'h0000_0000;
      alu_q  <= 32'h0000_0000;
      ld_q   <= 32'h0000_0000;
    end else begin
      if (cap_s) begin
        pc_q   <= pc_Mem;
        inst_q <= inst_Mem;
        alu_q  <= alu_Mem;
      end
      if ((state_q == S_WAIT_LD) && dmem_rvalid && !flush_Wb) begin
        ld_q <= align_load(inst_q[14:12], alu_q[1:0], dmem_rdata);
      end
    end
  end

  // Retired-instruction counter; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= {RET_W{1'b0}};
    end else if (state_q == S_WRITE) begin
      instret_q <= instret_q + {{(RET_W-1){1'b0}}, 1'b1};
    end else begin
      instret_q <= instret_q;
    end
  end

  assign u_imm_s = {inst_q[31:12], 12'h000};

  // Result select and write-enable decode from the held instruction.
  always_comb begin
    result_s = 32'h0000_0000;
    wr_op_s  = 1'b0;
    case (inst_q[6:0])
      OP_LUI:   begin result_s = u_imm_s;             wr_op_s = 1'b1; end
      OP_AUIPC: begin result_s = pc_q + u_imm_s;      wr_op_s = 1'b1; end
      OP_JAL,
      OP_JALR:  begin result_s = pc_q + 32'd4;        wr_op_s = 1'b1; end
      OP_OP,
      OP_IMM:   begin result_s = alu_q;               wr_op_s = 1'b1; end
      OP_LOAD: begin
        result_s = ld_q;
        case (inst_q[14:12])
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: wr_op_s = 1'b1;
          default:                                wr_op_s = 1'b0;
        endcase
      end
      default: begin result_s = 32'h0000_0000; wr_op_s = 1'b0; end
    endcase
  end

  assign retire        = (state_q == S_WRITE);
  assign reg_write_en  = retire & wr_op_s & (inst_q[11:7] != 5'd0);
  assign wb_mux_out_Wb = retire ? result_s : 32'h0000_0000;
  assign inst_Wb       = inst_q;
  assign pc_Wb         = pc_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, ALU/LUI/JAL writeback,
// aligned loads with latency, x0/store suppression, flush and reset during a load.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_Mem, flush_Wb, dmem_rvalid;
  logic [31:0] pc_Mem, inst_Mem, alu_Mem, dmem_rdata;
  logic        ready_Mem, reg_write_en, retire;
  logic [31:0] inst_Wb, wb_mux_out_Wb, pc_Wb;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_ret = 64'd0;

  always #5 clk = ~clk;

  wb_stage #(.RET_W(64)) dut (
    .clk(clk), .reset(reset), .valid_Mem(valid_Mem), .ready_Mem(ready_Mem),
    .flush_Wb(flush_Wb), .pc_Mem(pc_Mem), .inst_Mem(inst_Mem), .alu_Mem(alu_Mem),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .reg_write_en(reg_write_en),
    .inst_Wb(inst_Wb), .wb_mux_out_Wb(wb_mux_out_Wb), .pc_Wb(pc_Wb),
    .retire(retire), .instret(instret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu);
    valid_Mem = 1'b1; pc_Mem = pc; inst_Mem = inst; alu_Mem = alu;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush_Wb = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    present(32'h40, 32'h00500093, 32'h5);
    tick(); tick();
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", reg_write_en); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire got %0b want 0", retire); end
    checks++; if (inst_Wb !== 32'h0 || pc_Wb !== 32'h0) begin errors++; $display("FAIL rst_hold got %h/%h want 0/0", inst_Wb, pc_Wb); end
    checks++; if (ready_Mem !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", ready_Mem); end
    valid_Mem = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (wb_mux_out_Wb !== 32'h0 || instret !== 64'd0) begin errors++; $display("FAIL rst_out got %h/%0d want 0/0", wb_mux_out_Wb, instret); end
    checks++; if (ready_Mem !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL rst_rel got ready=%0b ret=%0b want 1/0", ready_Mem, retire); end
  endtask

  task automatic test_addi();
    present(32'h0, 32'h00500093, 32'h5);
    tick(); valid_Mem = 1'b0;
    checks++; if (reg_write_en !== 1'b1 || wb_mux_out_Wb !== 32'h5) begin errors++; $display("FAIL addi_wr got we=%0b d=%h want 1/5", reg_write_en, wb_mux_out_Wb); end
    checks++; if (inst_Wb[11:7] !== 5'd1 || retire !== 1'b1) begin errors++; $display("FAIL addi_rd got rd=%0d ret=%0b want 1/1", inst_Wb[11:7], retire); end
    tick(); exp_ret = exp_ret + 64'd1;
    checks++; if (instret !== exp_ret || retire !== 1'b0 || wb_mux_out_Wb !== 32'h0) begin errors++; $display("FAIL addi_after got ret=%0d r=%0b d=%h want %0d/0/0", instret, retire, wb_mux_out_Wb, exp_ret); end
  endtask

  task automatic test_back_to_back();
    present(32'h80, 32'h123450B7, 32'h0);
    tick();
    present(32'h100, 32'h000000EF, 32'h0);
    checks++; if (wb_mux_out_Wb !== 32'h12345000 || retire !== 1'b1 || reg_write_en !== 1'b1) begin errors++; $display("FAIL lui got d=%h r=%0b want 12345000/1", wb_mux_out_Wb, retire); end
    tick(); valid_Mem = 1'b0;
    checks++; if (wb_mux_out_Wb !== 32'h104 || retire !== 1'b1 || pc_Wb !== 32'h100) begin errors++; $display("FAIL jal got d=%h r=%0b pc=%h want 104/1/100", wb_mux_out_Wb, retire, pc_Wb); end
    tick(); exp_ret = exp_ret + 64'd2;
    checks++; if (instret !== exp_ret || retire !== 1'b0) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", instret, exp_ret); end
  endtask

  task automatic do_load(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] exp_d,
                         input string nm);
    int rdy_hi;
    rdy_hi = 0;
    dmem_rdata = 32'h80FF7F01;
    present(32'h200, inst, alu);
    tick(); valid_Mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ready_Mem !== 1'b0 || retire !== 1'b0) rdy_hi++;
      if (i == 2) dmem_rvalid = 1'b1;
      if (i < 2) tick();
    end
    checks++; if (rdy_hi != 0) begin errors++; $display("FAIL %s_wait got %0d busy-cycle violations want 0", nm, rdy_hi); end
    tick(); dmem_rvalid = 1'b0;
    checks++; if (wb_mux_out_Wb !== exp_d || reg_write_en !== 1'b1 || ready_Mem !== 1'b1) begin errors++; $display("FAIL %s_data got d=%h we=%0b want %h/1", nm, wb_mux_out_Wb, reg_write_en, exp_d); end
    tick(); exp_ret = exp_ret + 64'd1;
  endtask

  task automatic test_loads();
    do_load(32'h00000103, 32'h2, 32'hFFFFFFFF, "lb");
    do_load(32'h00005103, 32'h2, 32'h000080FF, "lhu");
    checks++; if (instret !== exp_ret) begin errors++; $display("FAIL ld_cnt got %0d want %0d", instret, exp_ret); end
  endtask

  task automatic test_x0_store();
    dmem_rvalid = 1'b1;
    present(32'h300, 32'h00100013, 32'h1);
    tick();
    present(32'h304, 32'h00112023, 32'h8);
    checks++; if (retire !== 1'b1 || reg_write_en !== 1'b0) begin errors++; $display("FAIL x0 got r=%0b we=%0b want 1/0", retire, reg_write_en); end
    tick(); valid_Mem = 1'b0; dmem_rvalid = 1'b0;
    checks++; if (retire !== 1'b1 || reg_write_en !== 1'b0) begin errors++; $display("FAIL store got r=%0b we=%0b want 1/0", retire, reg_write_en); end
    tick(); exp_ret = exp_ret + 64'd2;
    checks++; if (instret !== exp_ret) begin errors++; $display("FAIL st_cnt got %0d want %0d", instret, exp_ret); end
  endtask

  task automatic test_flush_reset();
    present(32'h400, 32'h00002103, 32'h10);
    tick(); valid_Mem = 1'b0;
    flush_Wb = 1'b1; dmem_rvalid = 1'b1;
    tick(); flush_Wb = 1'b0; dmem_rvalid = 1'b0;
    checks++; if (retire !== 1'b0 || reg_write_en !== 1'b0 || ready_Mem !== 1'b1) begin errors++; $display("FAIL flush got r=%0b we=%0b rdy=%0b want 0/0/1", retire, reg_write_en, ready_Mem); end
    tick();
    checks++; if (instret !== exp_ret || retire !== 1'b0) begin errors++; $display("FAIL flush_cnt got %0d want %0d", instret, exp_ret); end
    present(32'h500, 32'h00002103, 32'h10);
    tick(); valid_Mem = 1'b0;
    reset = 1'b0; #1;
    checks++; if (ready_Mem !== 1'b1 || instret !== 64'd0) begin errors++; $display("FAIL rst_ld got rdy=%0b cnt=%0d want 1/0", ready_Mem, instret); end
    tick(); reset = 1'b1; dmem_rvalid = 1'b1;
    tick(); dmem_rvalid = 1'b0;
    checks++; if (retire !== 1'b0 || reg_write_en !== 1'b0) begin errors++; $display("FAIL rst_ld_nowr got r=%0b we=%0b want 0/0", retire, reg_write_en); end
  endtask

  initial begin
    valid_Mem = 1'b0; pc_Mem = 32'h0; inst_Mem = 32'h0; alu_Mem = 32'h0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_loads();
    test_x0_store();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I pipeline and the writer side of the decode-stage register file. It holds one instruction from the memory stage and waits for data-memory read data when that instruction is a load. It forms the final result (ALU, aligned load, LUI/AUIPC immediate, link address) and drives `reg_write_en`, `inst_Wb` and `wb_mux_out_Wb` into the register file. It also counts retired instructions.

## Interface
- `RET_W`, default 64: width of the retired-instruction counter.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; asserting it (0) immediately forces the reset state.
- `valid_Mem`, input, 1: the memory stage presents an instruction.
- `ready_Mem`, output, 1: the stage can capture this cycle.
- `flush_Wb`, input, 1: blocks capture this cycle and cancels a pending load.
- `pc_Mem`, input, 32: PC of the presented instruction.
- `inst_Mem`, input, 32: instruction word.
- `alu_Mem`, input, 32: ALU result; this is the effective address for loads.
- `dmem_rdata`, input, 32: word-aligned data-memory read data.
- `dmem_rvalid`, input, 1: `dmem_rdata` is valid this cycle.
- `reg_write_en`, output, 1: register-file write strobe.
- `inst_Wb`, output, 32: held instruction; rd = `[11:7]`.
- `wb_mux_out_Wb`, output, 32: write data.
- `pc_Wb`, output, 32: held PC.
- `retire`, output, 1: one-cycle pulse per retired instruction.
- `instret`, output, RET_W: retired-instruction count.

## Operation
- **Capture.** `cap = valid_Mem & ready_Mem & ~flush_Wb`. On `cap`, latch `pc_Mem`, `inst_Mem` and `alu_Mem`.
- **`ready_Mem`.** 1 in EMPTY and WRITE, 0 in WAIT_LD. It does not depend on `flush_Wb`.
- **EMPTY state:**
  - Load opcode (0000011): on `cap` go to WAIT_LD.
  - Any other opcode: on `cap` go to WRITE.
- **WAIT_LD state:**
  - `dmem_rvalid` is sampled only in this state; earlier pulses are ignored.
  - On `dmem_rvalid`, register the aligned load result and go to WRITE.
  - `flush_Wb` (with or without `dmem_rvalid`) goes to EMPTY with no write and no retire. Flush has priority.
- **WRITE state:**
  - The held instruction writes back and retires this cycle.
  - Next state is decided by `cap` and the new opcode, exactly as from EMPTY; with no `cap`, go to EMPTY.
  - `flush_Wb` does not cancel the write in progress.
- **Result select (U-imm = `{inst[31:12], 12'b0}`):**
  - LUI 0110111: U-imm.
  - AUIPC 0010111: `pc + U-imm`.
  - JAL 1101111 / JALR 1100111: `pc + 4`.
  - OP 0110011 / OP-IMM 0010011: `alu`.
  - LOAD: aligned load data.
  - All additions are mod 2^32.
- **No-write opcodes.** STORE, BRANCH, FENCE, SYSTEM and unknown opcodes retire with `reg_write_en = 0`.
- **Load alignment.** Byte offset is `alu[1:0]`.
  - funct3 000 LB: byte at offset, sign-extended.
  - funct3 100 LBU: byte at offset, zero-extended.
  - funct3 001 LH: halfword selected by `alu[1]`, sign-extended; `alu[0]` ignored.
  - funct3 101 LHU: halfword selected by `alu[1]`, zero-extended; `alu[0]` ignored.
  - funct3 010 LW: full word; `alu[1:0]` ignored.
  - funct3 011/110/111: result 0, with the write suppressed.
- **`reg_write_en`** = state WRITE & writing opcode & rd ≠ 0. Writes to x0 are always suppressed.
- **`wb_mux_out_Wb`.** The selected result in WRITE, 0 in every other state.
- **`retire`** = (state == WRITE). `instret` increments by 1 on each `retire` and wraps from 2^RET_W−1 to 0.

## Timing
- **Reset values:**
  - state EMPTY.
  - `reg_write_en`, `retire`: 0.
  - `wb_mux_out_Wb`, `inst_Wb`, `pc_Wb`: 0.
  - `instret`: 0.
  - `ready_Mem`: 1, but nothing is captured while `reset` = 0.
- **Non-load latency.** Capture at edge N; WRITE in cycle N+1; the register file samples `reg_write_en` / `wb_mux_out_Wb` at edge N+1.
- **Load latency.** Capture at N, then WAIT_LD. If `dmem_rvalid` arrives at edge M > N, WRITE occurs in cycle M+1. `ready_Mem` stays 0 from N to M.
- **Back-to-back non-loads.** One retirement per cycle, with no bubbles.
- **Outputs.**
  - `inst_Wb` and `pc_Wb` are registered and stay stable until the next capture.
  - `reg_write_en`, `wb_mux_out_Wb` and `retire` are decoded from registered state only; there is no combinational path from any input.
- **Reset mid-load.** Asserting reset in WAIT_LD discards the load and returns to EMPTY.

## Test plan
- **Reset.** Drive reset = 0, then 1 → all outputs 0, `ready_Mem` = 1, `instret` = 0.
- **ADDI.** Capture `inst 0x00500093` (addi x1), `alu` = 5 → next cycle `reg_write_en` = 1, `wb_mux_out_Wb` = 5, `inst_Wb[11:7]` = 1, `instret` = 1.
- **LUI / JAL.**
  - LUI `0x123450B7` → write data `0x12345000`.
  - JAL at pc `0x100` → write data `0x104`.
  - Back-to-back, these give two consecutive `retire` pulses.
- **LB then LHU.** `dmem_rdata` = `0x80FF7F01`.
  - LB, `alu` = 0x2 → `0xFFFFFFFF`.
  - LHU, `alu` = 0x2 → `0x000080FF`.
  - `dmem_rvalid` arrives 3 cycles after capture → `ready_Mem` = 0 for those 3 cycles, then WRITE.
- **x0 and store.**
  - `addi x0` → `retire` = 1, `reg_write_en` = 0.
  - Store `0x00112023` → retires, no write.
- **Flush and reset during WAIT_LD.**
  - Load pending, then `flush_Wb` = 1 together with `dmem_rvalid` → EMPTY, no write, `instret` unchanged.
  - Reset in WAIT_LD → EMPTY.
